// File: rtl/dec_pkg.sv
// Shared types and helpers for the decimal-key front end (dec_key_debounce -> dec_to_bin).
package dec_pkg;

    localparam int N_KEYS = 7;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DEBOUNCE = 3'd1,
        PRESSED  = 3'd2,
        REJECT   = 3'd3,
        RELEASE  = 3'd4
    } key_state_t;

    // True when exactly one key line is set: nonzero and a power of two.
    function automatic logic onehot_chk(input logic [N_KEYS-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/dec_key_debounce_sync.sv
// Parameterised-width two-flop synchroniser with asynchronous active-low reset.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/dec_key_debounce.sv
// Synchronises, debounces and one-hot-qualifies seven raw key lines for dec_to_bin.
module dec_key_debounce
    import dec_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] i_key,
    output logic       o_d1,
    output logic       o_d2,
    output logic       o_d3,
    output logic       o_d4,
    output logic       o_d5,
    output logic       o_d6,
    output logic       o_d7,
    output logic       o_valid,
    output logic       o_err,
    output logic       o_busy
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC);

    logic [N_KEYS-1:0] sync_key;
    logic [N_KEYS-1:0] prev_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    key_state_t        state_q, state_d;
    logic [N_KEYS-1:0] key_q, key_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic              busy_q;
    logic              changed;
    logic              stable;

    sync_2ff #(
        .WIDTH (N_KEYS)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (i_key),
        .q_o   (sync_key)
    );

    // Stable also requires no change this cycle so a fresh edge never rides a saturated count.
    always_comb begin
        changed = (sync_key != prev_q);
        stable  = (cnt_q == CNT_MAX) && !changed;
        cnt_d   = cnt_q;
        if (changed || (state_q == IDLE && sync_key != '0)) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (sync_key != '0) begin
                    state_d = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (stable) begin
                    if (sync_key == '0) begin
                        state_d = IDLE;
                    end else if (onehot_chk(sync_key)) begin
                        state_d = PRESSED;
                        key_d   = sync_key;
                        valid_d = 1'b1;
                    end else begin
                        state_d = REJECT;
                        err_d   = 1'b1;
                    end
                end
            end
            PRESSED: begin
                if (sync_key != key_q) begin
                    state_d = RELEASE;
                end
            end
            REJECT: begin
                if (changed) begin
                    state_d = RELEASE;
                end
            end
            // Only a stable all-released pattern rearms; the held key stays visible until then.
            RELEASE: begin
                if (stable && sync_key == '0) begin
                    state_d = IDLE;
                    key_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                key_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q  <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
            key_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            prev_q  <= sync_key;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            key_q   <= key_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign o_d1    = key_q[0];
    assign o_d2    = key_q[1];
    assign o_d3    = key_q[2];
    assign o_d4    = key_q[3];
    assign o_d5    = key_q[4];
    assign o_d6    = key_q[5];
    assign o_d7    = key_q[6];
    assign o_valid = valid_q;
    assign o_err   = err_q;
    assign o_busy  = busy_q;

endmodule

// File: tb/tb_dec_key_debounce.sv
// Scoreboard bench for dec_key_debounce: a run-length key model predicts strobes, held lines and busy.
module tb_dec_key_debounce;

    localparam int DEB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] i_key = '0;
    logic       o_d1, o_d2, o_d3, o_d4, o_d5, o_d6, o_d7;
    logic       o_valid, o_err, o_busy;
    logic [6:0] dut_d;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    dec_key_debounce #(
        .DEBOUNCE_CYC (DEB)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_key   (i_key),
        .o_d1    (o_d1),
        .o_d2    (o_d2),
        .o_d3    (o_d3),
        .o_d4    (o_d4),
        .o_d5    (o_d5),
        .o_d6    (o_d6),
        .o_d7    (o_d7),
        .o_valid (o_valid),
        .o_err   (o_err),
        .o_busy  (o_busy)
    );

    always #5 clk = ~clk;

    assign dut_d = {o_d7, o_d6, o_d5, o_d4, o_d3, o_d2, o_d1};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: a raw key pattern counts as settled once DEB+2 consecutive
    // samples agree; its effect appears on the outputs two edges later.
    typedef struct {
        bit         is_err;
        logic [6:0] key;
        int         due;
    } ev_t;

    ev_t        evq[$];
    logic [6:0] last;
    int         run;
    bit         locked;
    bit         dirty;
    logic [6:0] md;
    logic [6:0] dh[3];
    bit         bh[3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last   = '0;
            run    = DEB + 3;
            locked = 1'b0;
            dirty  = 1'b0;
            md     = '0;
            for (int i = 0; i < 3; i++) begin
                dh[i] = '0;
                bh[i] = 1'b0;
            end
            evq.delete();
        end else begin
            cyc++;
            if (i_key == last) begin
                if (run < DEB + 3) run++;
            end else begin
                run  = 1;
                last = i_key;
            end
            if (i_key != '0) dirty = 1'b1;
            if (run == DEB + 2) begin
                if (last == '0) begin
                    locked = 1'b0;
                    dirty  = 1'b0;
                    md     = '0;
                end else if (!locked) begin
                    locked = 1'b1;
                    if ($countones(last) == 1) begin
                        md = last;
                        evq.push_back('{is_err: 1'b0, key: last, due: cyc + 2});
                    end else begin
                        evq.push_back('{is_err: 1'b1, key: 7'd0, due: cyc + 2});
                    end
                end
            end
            dh[2] = dh[1]; dh[1] = dh[0]; dh[0] = md;
            bh[2] = bh[1]; bh[1] = bh[0]; bh[0] = dirty;
        end
    end

    // Monitor: pops an expected event whenever the DUT strobes, checks held lines every cycle.
    always @(negedge clk) begin
        ev_t e;
        if (!rst_n) begin
            chk("reset_outputs", {22'd0, o_busy, o_err, o_valid, dut_d}, 32'd0);
        end else begin
            chk("held_keys", {25'd0, dut_d}, {25'd0, dh[2]});
            chk("busy", {31'd0, o_busy}, {31'd0, bh[2]});
            chk("valid_err_exclusive", {31'd0, o_valid & o_err}, 32'd0);
            if (o_valid || o_err) begin
                if (evq.size() == 0) begin
                    chk("unexpected_strobe", {30'd0, o_err, o_valid}, 32'd0);
                end else begin
                    e = evq.pop_front();
                    chk("strobe_kind", {30'd0, o_err, o_valid}, e.is_err ? 32'd2 : 32'd1);
                    chk("strobe_cycle", cyc, e.due);
                    if (!e.is_err) chk("accepted_key", {25'd0, dut_d}, {25'd0, e.key});
                end
            end else if (evq.size() != 0 && evq[0].due <= cyc) begin
                e = evq.pop_front();
                chk("strobe_at_due_cycle", {30'd0, o_err, o_valid}, e.is_err ? 32'd2 : 32'd1);
            end
        end
    end

    task automatic hold(input logic [6:0] k, input int n);
        i_key = k;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        logic [6:0] k;
        int         len;
        int         r;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        hold(7'b0000001, 30); hold(7'b0000000, 30);
        for (int i = 0; i < 7; i++) begin
            hold(7'b0010000, 3); hold(7'b0000000, 3);
        end
        hold(7'b0010000, 30); hold(7'b0000000, 30);
        hold(7'b1000100, 30); hold(7'b0000000, 30);
        hold(7'b1000000, 30); hold(7'b1000100, 30); hold(7'b0000000, 30);

        i_key = 7'b0001000;
        repeat (10) @(negedge clk);
        pulse_reset();
        repeat (25) @(negedge clk);
        pulse_reset();
        hold(7'b0001000, 30); hold(7'b0000000, 30);

        hold(7'b0000001, 25); hold(7'b0000000, 25);
        hold(7'b0010000, 25); hold(7'b0000000, 25);
        hold(7'b1000000, 25); hold(7'b0000000, 25);

        hold(7'b0000010, DEB + 1); hold(7'b0000000, 30);
        hold(7'b0000010, DEB + 2); hold(7'b0000000, 30);
        hold(7'b0000100, 30); hold(7'b0000000, DEB + 1); hold(7'b0000100, 10); hold(7'b0000000, 30);

        for (int s = 0; s < 80; s++) begin
            r = $urandom_range(0, 9);
            if (r < 3) k = 7'd0;
            else if (r < 7) k = 7'(1 << $urandom_range(0, 6));
            else k = 7'($urandom_range(1, 127));
            if ($urandom_range(0, 2) == 0) len = $urandom_range(DEB, DEB + 4);
            else len = $urandom_range(1, 40);
            hold(k, len);
            if ($urandom_range(0, 24) == 0) pulse_reset();
        end
        hold(7'b0000000, 40);

        chk("no_pending_events", evq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
